// File: rtl/multi_clk_divider.sv
// Multi-channel 50%-duty clock divider with per-channel enable and
// glitch-free runtime reload of each channel's divide value.
module multi_clk_divider #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 4999,
  parameter int CH_W        = 4
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                load_valid,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [CNT_W-1:0]    load_value,
  output logic                load_ready,
  output logic [CHANNELS-1:0] div_clk,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]    cnt         [CHANNELS];
  logic [CNT_W-1:0]    active_div  [CHANNELS];
  logic [CNT_W-1:0]    pending_div [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] terminal;
  logic [CHANNELS-1:0] apply;
  logic                accept;

  // Out-of-range channels leave sel clear, so they are accepted and dropped.
  always_comb begin
    sel        = '0;
    load_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (32'(load_ch) == i) begin
        sel[i]     = 1'b1;
        load_ready = ~pending[i];
      end
    end
  end

  assign accept = load_valid & load_ready;

  always_comb begin
    terminal = '0;
    apply    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      terminal[i] = (cnt[i] == active_div[i]);
      apply[i]    = pending[i] & (~en[i] | terminal[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]         <= '0;
        active_div[i]  <= DIV_RST;
        pending_div[i] <= '0;
      end
      pending <= '0;
      div_clk <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!en[i]) begin
          cnt[i]     <= '0;
          div_clk[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (terminal[i]) begin
          cnt[i]     <= '0;
          div_clk[i] <= ~div_clk[i];
          tick[i]    <= ~div_clk[i];
        end else begin
          cnt[i]     <= cnt[i] + CNT_W'(1);
          tick[i]    <= 1'b0;
        end

        // A channel never accepts while pending, so apply and accept
        // cannot collide on the same channel.
        if (apply[i]) begin
          active_div[i] <= pending_div[i];
          pending[i]    <= 1'b0;
        end
        if (accept && sel[i]) begin
          pending_div[i] <= load_value;
          pending[i]     <= 1'b1;
        end
      end
    end
  end

endmodule
